// File: rtl/nmcu_pkg.sv
// nmcu_pkg: shared array geometry, datapath widths and PE streamer state encoding.
package nmcu_pkg;
    localparam int DATA_WIDTH   = 8;
    localparam int PSUM_WIDTH   = 24;
    localparam int PE_ROWS      = 4;
    localparam int PE_COLS      = 4;
    localparam int PE_ROW_IDX_W = $clog2(PE_ROWS);
    typedef enum logic [1:0] {STRM_IDLE, STRM_STREAM, STRM_WAIT, STRM_OUTPUT} pe_strm_state_e;
endpackage

// File: rtl/pe_tile_streamer_snapshot.sv
// pe_result_snapshot: holds the finished result matrix so writeback can drain it row by row
// while the array is free to start the next job.
module pe_result_snapshot #(
    parameter int PSUM_WIDTH = 24,
    parameter int PE_ROWS    = 4,
    parameter int PE_COLS    = 4,
    parameter int ROW_W      = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          capture,
    input  logic [PE_ROWS-1:0][PE_COLS-1:0][PSUM_WIDTH-1:0] result,
    input  logic [ROW_W-1:0]                              row_sel,
    output logic [PE_COLS-1:0][PSUM_WIDTH-1:0]            row_data
);
    logic [PE_ROWS-1:0][PE_COLS-1:0][PSUM_WIDTH-1:0] snap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) snap <= '0;
        else if (capture) snap <= result;
    end

    assign row_data = snap[row_sel];
endmodule

// File: rtl/pe_tile_streamer.sv
// pe_tile_streamer: streams K operand beats to the PE array, counts returned done pulses,
// snapshots the result tile and drains it row by row to writeback.
module pe_tile_streamer #(
    parameter int DATA_WIDTH     = nmcu_pkg::DATA_WIDTH,
    parameter int PSUM_WIDTH     = nmcu_pkg::PSUM_WIDTH,
    parameter int PE_ROWS        = nmcu_pkg::PE_ROWS,
    parameter int PE_COLS        = nmcu_pkg::PE_COLS,
    parameter int K_W            = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            start_valid_i,
    output logic                                            start_ready_o,
    input  logic [K_W-1:0]                                  k_len_i,
    input  logic                                            accumulate_i,
    input  logic                                            src_valid_i,
    output logic                                            src_ready_o,
    input  logic [PE_ROWS-1:0][DATA_WIDTH-1:0]              src_a_i,
    input  logic [PE_COLS-1:0][DATA_WIDTH-1:0]              src_b_i,
    output logic                                            pe_cmd_valid_o,
    input  logic                                            pe_cmd_ready_i,
    output logic [PE_ROWS-1:0]                              pe_accum_en_o,
    output logic [PE_ROWS-1:0][DATA_WIDTH-1:0]              pe_operand_a_o,
    output logic [PE_COLS-1:0][DATA_WIDTH-1:0]              pe_operand_b_o,
    input  logic                                            pe_done_i,
    input  logic [PE_ROWS-1:0][PE_COLS-1:0][PSUM_WIDTH-1:0] pe_result_i,
    output logic                                            res_valid_o,
    input  logic                                            res_ready_i,
    output logic [$clog2(PE_ROWS)-1:0]                      res_row_o,
    output logic [PE_COLS-1:0][PSUM_WIDTH-1:0]              res_data_o,
    output logic                                            res_last_o,
    output logic                                            busy_o,
    output logic                                            done_o,
    output logic                                            err_o
);
    import nmcu_pkg::*;

    localparam int ROW_W = $clog2(PE_ROWS);

    pe_strm_state_e                   state;
    logic [K_W-1:0]                   k_len;
    logic [K_W-1:0]                   sent_cnt;
    logic [K_W-1:0]                   done_cnt;
    logic [K_W-1:0]                   idle_cnt;
    logic                             accumulate;
    logic [ROW_W-1:0]                 row;
    logic                             fire;
    logic                             counting;
    logic                             done_hit;
    logic [PE_COLS-1:0][PSUM_WIDTH-1:0] snap_row;

    assign fire     = state == STRM_STREAM && src_valid_i && pe_cmd_ready_i;
    assign counting = state == STRM_STREAM || state == STRM_WAIT;
    assign done_hit = counting && pe_done_i && done_cnt + K_W'(1) == k_len;

    assign start_ready_o  = state == STRM_IDLE;
    assign busy_o         = state != STRM_IDLE;
    assign pe_cmd_valid_o = state == STRM_STREAM && src_valid_i;
    assign src_ready_o    = state == STRM_STREAM && pe_cmd_ready_i;
    assign pe_operand_a_o = state == STRM_STREAM ? src_a_i : '0;
    assign pe_operand_b_o = state == STRM_STREAM ? src_b_i : '0;
    // only the very first beat of a non-accumulating job clears the psums
    assign pe_accum_en_o  = state == STRM_STREAM && (accumulate || sent_cnt != '0) ? '1 : '0;
    assign res_valid_o    = state == STRM_OUTPUT;
    assign res_row_o      = row;
    assign res_last_o     = res_valid_o && row == ROW_W'(PE_ROWS - 1);
    assign res_data_o     = res_valid_o ? snap_row : '0;

    pe_result_snapshot #(
        .PSUM_WIDTH(PSUM_WIDTH),
        .PE_ROWS   (PE_ROWS),
        .PE_COLS   (PE_COLS),
        .ROW_W     (ROW_W)
    ) u_snapshot (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (done_hit),
        .result  (pe_result_i),
        .row_sel (row),
        .row_data(snap_row)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STRM_IDLE;
            k_len      <= '0;
            accumulate <= 1'b0;
            sent_cnt   <= '0;
            done_cnt   <= '0;
            idle_cnt   <= '0;
            row        <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (counting && pe_done_i) done_cnt <= done_cnt + K_W'(1);
            if (fire) sent_cnt <= sent_cnt + K_W'(1);
            case (state)
                STRM_IDLE: begin
                    if (start_valid_i) begin
                        k_len      <= k_len_i;
                        accumulate <= accumulate_i;
                        err_o      <= 1'b0;
                        sent_cnt   <= '0;
                        done_cnt   <= '0;
                        row        <= '0;
                        if (k_len_i == '0) done_o <= 1'b1;
                        else state <= STRM_STREAM;
                    end
                end
                STRM_STREAM: begin
                    if (done_hit) state <= STRM_OUTPUT;
                    else if (fire && sent_cnt == k_len - K_W'(1)) begin
                        state    <= STRM_WAIT;
                        idle_cnt <= '0;
                    end
                end
                STRM_WAIT: begin
                    if (done_hit) state <= STRM_OUTPUT;
                    else if (pe_done_i) idle_cnt <= '0;
                    else if (idle_cnt == K_W'(TIMEOUT_CYCLES - 1)) begin
                        err_o  <= 1'b1;
                        done_o <= 1'b1;
                        state  <= STRM_IDLE;
                    end else idle_cnt <= idle_cnt + K_W'(1);
                end
                STRM_OUTPUT: begin
                    if (res_ready_i) begin
                        row <= row + ROW_W'(1);
                        if (res_last_o) begin
                            done_o <= 1'b1;
                            state  <= STRM_IDLE;
                        end
                    end
                end
                default: state <= STRM_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_tile_streamer.sv
// tb_pe_tile_streamer: drives tile jobs into pe_tile_streamer against a behavioural PE array load
// and checks drained rows against a job-level matrix model through a scoreboard.
module tb_pe_tile_streamer;
    import nmcu_pkg::*;

    typedef logic [PE_ROWS-1:0][DATA_WIDTH-1:0]              vec_a_t;
    typedef logic [PE_COLS-1:0][DATA_WIDTH-1:0]              vec_b_t;
    typedef logic [PE_COLS-1:0][PSUM_WIDTH-1:0]              row_t;
    typedef logic [PE_ROWS-1:0][PE_COLS-1:0][PSUM_WIDTH-1:0] mat_t;
    typedef struct {
        logic [PE_ROW_IDX_W-1:0] row;
        row_t                    data;
        logic                    last;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start_valid_i = 1'b0;
    logic                    start_ready_o;
    logic [15:0]             k_len_i = '0;
    logic                    accumulate_i = 1'b0;
    logic                    src_valid_i = 1'b0;
    logic                    src_ready_o;
    vec_a_t                  src_a_i = '0;
    vec_b_t                  src_b_i = '0;
    logic                    pe_cmd_valid_o;
    logic                    pe_cmd_ready_i = 1'b1;
    logic [PE_ROWS-1:0]      pe_accum_en_o;
    vec_a_t                  pe_operand_a_o;
    vec_b_t                  pe_operand_b_o;
    logic                    pe_done_i;
    mat_t                    pe_result_i;
    logic                    res_valid_o;
    logic                    res_ready_i = 1'b1;
    logic [PE_ROW_IDX_W-1:0] res_row_o;
    row_t                    res_data_o;
    logic                    res_last_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;

    int checks = 0;
    int errors = 0;
    int fire_cnt = 0;
    int done_cnt = 0;
    int rv_cnt = 0;
    bit last_fire = 1'b0;
    bit kill_done = 1'b0;
    logic [PE_ROWS-1:0] accum_log[$];
    exp_t   sb[$];
    vec_a_t beat_a[8];
    vec_b_t beat_b[8];
    mat_t   exp_c = '0;
    mat_t   psum;
    logic [2:0] dpipe;

    always #5 clk = ~clk;

    pe_tile_streamer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_valid_i (start_valid_i),
        .start_ready_o (start_ready_o),
        .k_len_i       (k_len_i),
        .accumulate_i  (accumulate_i),
        .src_valid_i   (src_valid_i),
        .src_ready_o   (src_ready_o),
        .src_a_i       (src_a_i),
        .src_b_i       (src_b_i),
        .pe_cmd_valid_o(pe_cmd_valid_o),
        .pe_cmd_ready_i(pe_cmd_ready_i),
        .pe_accum_en_o (pe_accum_en_o),
        .pe_operand_a_o(pe_operand_a_o),
        .pe_operand_b_o(pe_operand_b_o),
        .pe_done_i     (pe_done_i),
        .pe_result_i   (pe_result_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_row_o     (res_row_o),
        .res_data_o    (res_data_o),
        .res_last_o    (res_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    // PE array load: outer-product accumulate per beat, done pulse three cycles after each beat
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum  <= '0;
            dpipe <= '0;
        end else begin
            dpipe <= {dpipe[1:0], pe_cmd_valid_o && pe_cmd_ready_i};
            if (pe_cmd_valid_o && pe_cmd_ready_i)
                for (int i = 0; i < PE_ROWS; i++)
                    for (int j = 0; j < PE_COLS; j++)
                        psum[i][j] <= (pe_accum_en_o[i] ? psum[i][j] : '0) +
                                      PSUM_WIDTH'(pe_operand_a_o[i]) * PSUM_WIDTH'(pe_operand_b_o[j]);
        end
    end

    assign pe_done_i   = dpipe[2] && !kill_done;
    assign pe_result_i = psum;

    task automatic tick;
        exp_t e;
        @(negedge clk);
        last_fire = pe_cmd_valid_o && pe_cmd_ready_i;
        if (last_fire) begin
            fire_cnt++;
            accum_log.push_back(pe_accum_en_o);
        end
        if (done_o) done_cnt++;
        if (res_valid_o) rv_cnt++;
        if (res_valid_o && res_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL row_unexpected: got row %0d with no row expected", res_row_o);
            end else begin
                e = sb.pop_front();
                if (res_row_o !== e.row || res_data_o !== e.data || res_last_o !== e.last) begin
                    errors++;
                    $display("FAIL row_data: got row %0d last %0b data %h, expected row %0d last %0b data %h",
                             res_row_o, res_last_o, res_data_o, e.row, e.last, e.data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input int k, input bit acc);
        exp_t e;
        int s;
        for (int i = 0; i < PE_ROWS; i++) begin
            for (int j = 0; j < PE_COLS; j++) begin
                s = acc ? int'(exp_c[i][j]) : 0;
                for (int b = 0; b < k; b++) s += int'(beat_a[b][i]) * int'(beat_b[b][j]);
                exp_c[i][j] = PSUM_WIDTH'(s);
            end
            e.row  = PE_ROW_IDX_W'(i);
            e.data = exp_c[i];
            e.last = i == PE_ROWS - 1;
            sb.push_back(e);
        end
    endtask

    task automatic run_job(input int k, input bit acc, input bit toggle, input int hold_row,
                           input int hold_len, input bit expect_rows, output int cyc);
        int   b = 0;
        int   held = 0;
        bit   holding;
        row_t hold_data = '0;
        fire_cnt = 0;
        done_cnt = 0;
        rv_cnt = 0;
        accum_log.delete();
        if (expect_rows) push_expected(k, acc);
        start_valid_i = 1'b1;
        k_len_i = 16'(k);
        accumulate_i = acc;
        tick;
        start_valid_i = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 1000) begin
            src_valid_i = b < k && (!toggle || cyc % 2 == 0);
            src_a_i = b < k ? beat_a[b] : '0;
            src_b_i = b < k ? beat_b[b] : '0;
            holding = res_valid_o && int'(res_row_o) == hold_row && held < hold_len;
            res_ready_i = !holding;
            if (holding) begin
                if (held == 0) hold_data = res_data_o;
                else begin
                    checks++;
                    if (res_data_o !== hold_data || int'(res_row_o) != hold_row) begin
                        errors++;
                        $display("FAIL hold_stable: got row %0d data %h, expected row %0d data %h",
                                 res_row_o, res_data_o, hold_row, hold_data);
                    end
                end
                held++;
            end
            tick;
            if (last_fire) b++;
            cyc++;
        end
        src_valid_i = 1'b0;
        res_ready_i = 1'b1;
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL job_done: no done_o within %0d cycles, expected a done pulse", cyc);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({start_ready_o, busy_o, done_o, err_o, res_valid_o, pe_cmd_valid_o, src_ready_o} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 1000000",
                     {start_ready_o, busy_o, done_o, err_o, res_valid_o, pe_cmd_valid_o, src_ready_o});
        end
        checks++;
        if (pe_accum_en_o !== '0 || pe_operand_a_o !== '0 || res_data_o !== '0 || res_row_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got accum %h opa %h data %h row %0d, expected all zero",
                     pe_accum_en_o, pe_operand_a_o, res_data_o, res_row_o);
        end
        rst_n = 1'b1;
        tick;
        checks++;
        if (start_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got ready %b busy %b, expected 1 0", start_ready_o, busy_o);
        end
    endtask

    task automatic load_identity_job;
        for (int b = 0; b < 4; b++) begin
            beat_a[b] = '0;
            beat_a[b][b] = 8'd1;
            for (int j = 0; j < PE_COLS; j++) beat_b[b][j] = DATA_WIDTH'(b * 4 + j + 1);
        end
    endtask

    task automatic test_basic;
        int cyc;
        load_identity_job();
        run_job(4, 1'b0, 1'b0, -1, 0, 1'b1, cyc);
        repeat (3) tick;
        checks++;
        if (fire_cnt != 4 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_counts: got beats %0d done %0d, expected 4 1", fire_cnt, done_cnt);
        end
        checks++;
        if (accum_log.size() != 4 || accum_log[0] !== 4'h0 || accum_log[1] !== 4'hF ||
            accum_log[2] !== 4'hF || accum_log[3] !== 4'hF) begin
            errors++;
            $display("FAIL basic_accum_en: got %p, expected 0 F F F", accum_log);
        end
        checks++;
        if (sb.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got %0d rows pending busy %b, expected 0 0", sb.size(), busy_o);
        end
    endtask

    task automatic test_src_stall;
        int cyc;
        load_identity_job();
        run_job(4, 1'b0, 1'b1, -1, 0, 1'b1, cyc);
        checks++;
        if (fire_cnt != 4 || done_cnt != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL stall_counts: got beats %0d done %0d pending %0d, expected 4 1 0",
                     fire_cnt, done_cnt, sb.size());
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        load_identity_job();
        run_job(4, 1'b0, 1'b0, 2, 5, 1'b1, cyc);
        checks++;
        if (rv_cnt != 9 || sb.size() != 0) begin
            errors++;
            $display("FAIL backpressure_rows: got valid cycles %0d pending %0d, expected 9 0", rv_cnt, sb.size());
        end
    endtask

    task automatic test_accumulate;
        int cyc;
        for (int b = 0; b < 3; b++) begin
            beat_a[b] = {PE_ROWS{8'd1}};
            beat_b[b] = {PE_COLS{8'd1}};
        end
        run_job(3, 1'b0, 1'b0, -1, 0, 1'b1, cyc);
        run_job(3, 1'b1, 1'b0, -1, 0, 1'b1, cyc);
        checks++;
        if (accum_log.size() != 3 || accum_log[0] !== 4'hF) begin
            errors++;
            $display("FAIL accum_first_beat: got %p, expected first beat F", accum_log);
        end
        run_job(3, 1'b0, 1'b0, -1, 0, 1'b1, cyc);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL accum_drain: got %0d rows pending, expected 0", sb.size());
        end
    endtask

    task automatic test_zero_len;
        fire_cnt = 0;
        done_cnt = 0;
        rv_cnt = 0;
        start_valid_i = 1'b1;
        k_len_i = '0;
        accumulate_i = 1'b0;
        tick;
        start_valid_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got done %b one cycle after start, expected 1", done_o);
        end
        repeat (5) tick;
        checks++;
        if (fire_cnt != 0 || rv_cnt != 0 || done_cnt != 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_traffic: got beats %0d rows %0d done %0d busy %b, expected 0 0 1 0",
                     fire_cnt, rv_cnt, done_cnt, busy_o);
        end
    endtask

    task automatic test_timeout_reset;
        int cyc;
        load_identity_job();
        kill_done = 1'b1;
        run_job(4, 1'b0, 1'b0, -1, 0, 1'b0, cyc);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || cyc != 261) begin
            errors++;
            $display("FAIL timeout: got err %b busy %b cycles %0d, expected 1 0 261", err_o, busy_o, cyc);
        end
        checks++;
        if (fire_cnt != 4 || rv_cnt != 0) begin
            errors++;
            $display("FAIL timeout_rows: got beats %0d rows %0d, expected 4 0", fire_cnt, rv_cnt);
        end
        kill_done = 1'b0;
        pe_cmd_ready_i = 1'b0;
        src_valid_i = 1'b1;
        start_valid_i = 1'b1;
        k_len_i = 16'd4;
        tick;
        start_valid_i = 1'b0;
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b1 || pe_cmd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL restart: got err %b busy %b cmd_valid %b, expected 0 1 1", err_o, busy_o, pe_cmd_valid_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_ready_o, busy_o, done_o, err_o, res_valid_o, pe_cmd_valid_o, src_ready_o} !== 7'b1000000 ||
            pe_operand_a_o !== '0 || pe_accum_en_o !== '0) begin
            errors++;
            $display("FAIL abort_reset: got ctrl %b opa %h accum %h, expected 1000000 0 0",
                     {start_ready_o, busy_o, done_o, err_o, res_valid_o, pe_cmd_valid_o, src_ready_o},
                     pe_operand_a_o, pe_accum_en_o);
        end
        src_valid_i = 1'b0;
        pe_cmd_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_src_stall();
        test_backpressure();
        test_accumulate();
        test_zero_len();
        test_timeout_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
